// File: rtl/sync_down_counter.sv
// sync_down_counter: loadable, enable-gated down counter with a one-cycle terminal-count pulse.
// Optional periodic auto-reload is enabled by defining DOWN_CNT_RELOAD_EN.
module sync_down_counter #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             zero,
    output logic             tc,
    output logic             busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
`ifdef DOWN_CNT_RELOAD_EN
    localparam logic [1:0] END_ST = RUN;
    logic [WIDTH-1:0] reload;
    // Remember the last loaded value so the count can restart from it after reaching zero
    always_ff @(posedge clk) begin
        if (reset)
            reload <= '0;
        else if (load)
            reload <= load_val;
    end
`else
    localparam logic [1:0] END_ST = DONE;
`endif
    logic [1:0] state;
    assign zero = (count == '0);
    assign busy = (state == RUN);
    // Load has priority over decrement; tc is raised only on the 1 -> 0 decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            state <= IDLE;
            tc    <= 1'b0;
        end else if (load) begin
            count <= load_val;
            state <= (load_val != '0) ? RUN : IDLE;
            tc    <= 1'b0;
        end else if (state == RUN && en) begin
            if (count == ONE) begin
                count <= '0;
                state <= END_ST;
                tc    <= 1'b1;
            end else if (count == '0) begin
`ifdef DOWN_CNT_RELOAD_EN
                count <= reload;
`endif
                tc    <= 1'b0;
            end else begin
                count <= count - ONE;
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sync_down_counter.sv
// tb_sync_down_counter: randomized and directed checks of sync_down_counter against a behavioural model.
module tb_sync_down_counter;
    localparam int W = 3;
    localparam int MAXV = (1 << W) - 1;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic en = 1'b0;
    logic [W-1:0] count;
    logic zero, tc, busy;
    int total = 0;
    int bad = 0;
    int m_count = 0;
    int m_reload = 0;
    bit m_run = 1'b0;
    bit m_tc = 1'b0;
    sync_down_counter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .load(load), .load_val(load_val), .en(en),
        .count(count), .zero(zero), .tc(tc), .busy(busy)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model(input bit r, input bit l, input int v, input bit e);
        if (r) begin
            m_count = 0; m_run = 0; m_tc = 0; m_reload = 0;
        end else if (l) begin
            m_count = v; m_run = (v != 0); m_tc = 0; m_reload = v;
        end else if (m_run && e) begin
            if (m_count == 0) begin
                m_count = m_reload;
                m_tc = 0;
            end else begin
                m_count = m_count - 1;
                m_tc = (m_count == 0);
`ifndef DOWN_CNT_RELOAD_EN
                if (m_count == 0) m_run = 0;
`endif
            end
        end else begin
            m_tc = 0;
        end
    endtask
    task automatic step(input bit r, input bit l, input int v, input bit e);
        @(negedge clk);
        reset = r; load = l; load_val = W'(v); en = e;
        @(posedge clk);
        model(r, l, v, e);
        #1;
        check("count", int'(count), m_count);
        check("zero", int'(zero), int'(m_count == 0));
        check("tc", int'(tc), int'(m_tc));
        check("busy", int'(busy), int'(m_run));
    endtask
    initial begin
        int pat[6];
        step(1, 0, 0, 0);
        check("rst_zero", int'(zero), 1);
        // reset mid-traffic
        step(0, 1, 6, 1);
        step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(1, 1, 5, 1);
        check("rst_count", int'(count), 0);
        check("rst_busy", int'(busy), 0);
        // load 5 and run continuously
        step(0, 1, 5, 0);
        check("seq", int'(count), 5);
        for (int i = 4; i >= 0; i--) begin
            step(0, 0, 0, 1);
            check("seq", int'(count), i);
        end
        check("seq_tc", int'(tc), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
`ifndef DOWN_CNT_RELOAD_EN
        check("hold0", int'(count), 0);
        check("done_busy", int'(busy), 0);
`endif
        // gated enable
        pat = '{1, 0, 0, 1, 1, 1};
        step(0, 1, 4, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, pat[i][0]);
        check("gated_end", int'(count), 0);
        // load wins over en mid-run
        step(0, 1, 6, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(0, 1, 2, 1);
        check("reload_mid", int'(count), 2);
        // reset mid-run and zero load
        step(0, 1, 7, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        step(0, 0, 0, 1);
        check("zload_busy", int'(busy), 0);
        // maximum load
        step(0, 1, MAXV, 0);
        for (int i = 0; i < MAXV + 3; i++) step(0, 0, 0, 1);
`ifdef DOWN_CNT_RELOAD_EN
        // periodic reload sequence
        step(0, 1, 3, 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 0, 0, 1);
            check("period", int'(count), (3 - ((i + 1) % 4)));
        end
`endif
        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, MAXV)), $urandom_range(0, 3) != 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
